// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a word-organised data array: byte/half/word access,
// sign/zero extension, alignment/range flags, 1- or 2-cycle response pipeline.
module data_mem_lsu #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wr_data_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rd_data_o,
  output logic                  rsp_err_align_o,
  output logic                  rsp_err_range_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(DEPTH_WORDS);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("data_mem_lsu: READ_LATENCY must be 1 or 2");
  end

  logic [31:0] mem_q [DEPTH_WORDS];

  logic                  accept;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [1:0]            lane;
  logic                  err_align;
  logic                  err_range;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wr_lanes;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [31:0]           ld_data;
  logic [31:0]           rsp_data_d;

  logic        s1_valid_q;
  logic [31:0] s1_data_q;
  logic        s1_ea_q;
  logic        s1_er_q;

  assign req_ready_o = ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  assign word_idx    = req_addr_i[ADDR_WIDTH-1:2];
  assign mem_idx     = word_idx[IDX_W-1:0];
  assign lane        = req_addr_i[1:0];
  assign err_range   = ({2'b00, word_idx} >= DEPTH_L);
  assign rd_word     = mem_q[mem_idx];
  assign rd_shift    = rd_word >> {lane, 3'b000};

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    err_align = 1'b0;
    be        = 4'b0000;
    wr_lanes  = req_wr_data_i;
    ld_data   = rd_word;
    case (req_size_i)
      2'b00: begin
        be       = 4'b0001 << lane;
        wr_lanes = {4{req_wr_data_i[7:0]}};
        ld_data  = {{24{~req_unsigned_i & rd_shift[7]}}, rd_shift[7:0]};
      end
      2'b01: begin
        err_align = lane[0];
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes  = {2{req_wr_data_i[15:0]}};
        ld_data   = {{16{~req_unsigned_i & rd_shift[15]}}, rd_shift[15:0]};
      end
      2'b10: begin
        err_align = |lane;
        be        = 4'b1111;
      end
      default: err_align = 1'b1;
    endcase
  end

  assign wr_en      = accept & req_wr_i & ~err_align & ~err_range;
  assign rsp_data_d = (req_wr_i | err_align | err_range) ? 32'h0 : ld_data;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[mem_idx][8*l +: 8] <= wr_lanes[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'h0;
      s1_ea_q    <= 1'b0;
      s1_er_q    <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= rsp_data_d;
        s1_ea_q   <= err_align;
        s1_er_q   <= err_range;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic        s2_valid_q;
    logic [31:0] s2_data_q;
    logic        s2_ea_q;
    logic        s2_er_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= 32'h0;
        s2_ea_q    <= 1'b0;
        s2_er_q    <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
          s2_ea_q   <= s1_ea_q;
          s2_er_q   <= s1_er_q;
        end
      end
    end

    assign rsp_valid_o     = s2_valid_q;
    assign rsp_rd_data_o   = s2_data_q;
    assign rsp_err_align_o = s2_ea_q;
    assign rsp_err_range_o = s2_er_q;
  end else begin : g_lat1
    assign rsp_valid_o     = s1_valid_q;
    assign rsp_rd_data_o   = s1_data_q;
    assign rsp_err_align_o = s1_ea_q;
    assign rsp_err_range_o = s1_er_q;
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: one instance per read latency on shared stimulus,
// checked every cycle against a byte-array reference model.
module tb_data_mem_lsu;

  localparam int DEPTH = 100;
  localparam int AW    = 32;
  localparam int HMAX  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wr_data = '0;

  logic        rdy1, v1, ea1, er1;
  logic [31:0] rd1;
  logic        rdy2, v2, ea2, er2;
  logic [31:0] rd2;

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy1),
    .req_wr_i(req_wr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wr_data_i(req_wr_data), .rsp_valid_o(v1),
    .rsp_rd_data_o(rd1), .rsp_err_align_o(ea1), .rsp_err_range_o(er1)
  );

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy2),
    .req_wr_i(req_wr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wr_data_i(req_wr_data), .rsp_valid_o(v2),
    .rsp_rd_data_o(rd2), .rsp_err_align_o(ea2), .rsp_err_range_o(er2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ed     = 0;

  logic [7:0]  mb [DEPTH*4];
  logic        hist_v    [HMAX];
  logic [31:0] hist_rd   [HMAX];
  logic        hist_ea   [HMAX];
  logic        hist_er   [HMAX];
  logic        hist_dchk [HMAX];
  logic [31:0] hist_drd  [HMAX];
  logic        hist_dea  [HMAX];
  logic        hist_der  [HMAX];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected response derived from the access rules on a flat byte array.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic ea, output logic er);
    int n;
    logic [31:0] val;
    ea = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    er = (a / 4) >= 32'(DEPTH);
    rd = '0;
    if (ea || er) return;
    n = 1 << sz;
    if (wr) begin
      for (int k = 0; k < n; k++) mb[a + k] = 8'((d >> (8 * k)) & 32'hFF);
    end else begin
      val = '0;
      for (int k = 0; k < n; k++) val = val | (32'(mb[a + k]) << (8 * k));
      if (!uns && n == 1 && val >= 32'h80)   val = val + 32'hFFFFFF00;
      if (!uns && n == 2 && val >= 32'h8000) val = val + 32'hFFFF0000;
      rd = val;
    end
  endfunction

  task automatic check_dut(input string nm, input int i, input logic v, input logic [31:0] rd,
                           input logic ea, input logic er);
    logic ev;
    ev = (i >= 0) ? hist_v[i] : 1'b0;
    chk({nm, " rsp_valid"}, 32'(v), 32'(ev));
    if (ev) begin
      chk({nm, " rd_data"}, rd, hist_rd[i]);
      chk({nm, " err_align"}, 32'(ea), 32'(hist_ea[i]));
      chk({nm, " err_range"}, 32'(er), 32'(hist_er[i]));
      if (hist_dchk[i]) begin
        chk({nm, " directed rd_data"}, rd, hist_drd[i]);
        chk({nm, " directed err_align"}, 32'(ea), 32'(hist_dea[i]));
        chk({nm, " directed err_range"}, 32'(er), 32'(hist_der[i]));
      end
    end
    if (rst) begin
      chk({nm, " reset rd_data"}, rd, 32'h0);
      chk({nm, " reset err_align"}, 32'(ea), 32'h0);
      chk({nm, " reset err_range"}, 32'(er), 32'h0);
    end
  endtask

  task automatic stepd(input logic v, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic dchk,
                       input logic [31:0] drd, input logic dea, input logic der);
    logic acc;
    req_valid = v; req_wr = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wr_data = d;
    @(posedge clk);
    acc = v && !rst;
    hist_v[ed] = acc;
    hist_dchk[ed] = dchk && acc;
    hist_drd[ed] = drd; hist_dea[ed] = dea; hist_der[ed] = der;
    hist_rd[ed] = '0; hist_ea[ed] = 1'b0; hist_er[ed] = 1'b0;
    if (acc) model(wr, sz, uns, a, d, hist_rd[ed], hist_ea[ed], hist_er[ed]);
    #1;
    chk("req_ready L1", 32'(rdy1), 32'(!rst));
    chk("req_ready L2", 32'(rdy2), 32'(!rst));
    check_dut("L1", ed, v1, rd1, ea1, er1);
    check_dut("L2", ed - 1, v2, rd2, ea2, er2);
    ed++;
  endtask

  task automatic step(input logic v, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] d);
    stepd(v, wr, sz, uns, a, d, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) begin
      hist_v[i] = 1'b0; hist_dchk[i] = 1'b0;
    end
    #1 rst = 1'b1;
    #2;
    chk("reset rsp_valid L1", 32'(v1), 32'h0);
    chk("reset rsp_valid L2", 32'(v2), 32'h0);
    chk("reset rd_data L1", rd1, 32'h0);
    chk("reset rd_data L2", rd2, 32'h0);
    chk("reset flags L1", {30'h0, ea1, er1}, 32'h0);
    chk("reset flags L2", {30'h0, ea2, er2}, 32'h0);
    chk("reset req_ready L1", 32'(rdy1), 32'h0);
    chk("reset req_ready L2", 32'(rdy2), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
    idle(2);

    // Word store then load, back to back.
    stepd(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0);
    stepd(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(2);

    // Byte merge and extension variants.
    stepd(1'b1, 1'b1, 2'd0, 1'b0, 32'h12, 32'h55, 1'b1, 32'h0, 1'b0, 1'b0);
    stepd(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDE55BEEF, 1'b0, 1'b0);
    stepd(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0, 1'b0);
    stepd(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h000000DE, 1'b0, 1'b0);
    stepd(1'b1, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0);
    stepd(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 32'h0000DE55, 1'b0, 1'b0);
    idle(2);

    // Misalignment and reserved size.
    stepd(1'b1, 1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, 1'b1, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    stepd(1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    stepd(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    idle(2);

    // Range boundary, combined flags, no aliasing onto word 0.
    stepd(1'b1, 1'b0, 2'd2, 1'b0, 32'(DEPTH * 4), 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    stepd(1'b1, 1'b1, 2'd2, 1'b0, 32'(DEPTH * 4), 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0, 1'b1);
    stepd(1'b1, 1'b0, 2'd1, 1'b0, 32'(DEPTH * 4 + 1), 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'(DEPTH * 4 - 4), 32'h0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    idle(2);

    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, DEPTH * 4 + 15)), $urandom);
    end
    idle(2);

    // Reset with responses in flight; the accepted store must survive.
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    step(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    req_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async reset rsp_valid L1", 32'(v1), 32'h0);
    chk("async reset rsp_valid L2", 32'(v2), 32'h0);
    chk("async reset rd_data L1", rd1, 32'h0);
    chk("async reset rd_data L2", rd2, 32'h0);
    chk("async reset flags L1", {30'h0, ea1, er1}, 32'h0);
    chk("async reset flags L2", {30'h0, ea2, er2}, 32'h0);
    hist_v[ed - 1] = 1'b0;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    stepd(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Parametrised successor to the single-cycle data_mem. Adds RISC-V byte/half/word load-store access, sign/zero extension and misalignment/range error flags. Reads pass through a configurable 1- or 2-stage response pipeline with a valid handshake. Sits between the core's MEM stage and the data memory array and returns exactly one response per accepted request, in order.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2 not required).
ADDR_WIDTH, 32, byte-address width of req_addr.
READ_LATENCY, 1, cycles from request acceptance to rsp_valid; legal values 1 or 2, others rejected by elaboration assertion.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_wr  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_WIDTH  byte address
req_wr_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present, one-cycle pulse per request
rsp_rd_data  out  32  extended load data; 0 for stores and errored requests
rsp_err_align  out  1  misaligned access or reserved size
rsp_err_range  out  1  word index >= DEPTH_WORDS

Behaviour:
- Reset, async on rst rise, held while rst=1: rsp_valid=0, rsp_rd_data=0, rsp_err_align=0, rsp_err_range=0, all pipeline valid bits cleared, req_ready=0. Memory contents are not reset.
- req_ready=1 on every cycle after rst deasserts. There is no response backpressure. Full throughput is one request per cycle.
- Accept condition: req_valid & req_ready at a rising clk edge.
- Word index = req_addr[ADDR_WIDTH-1:2]. Byte lane = req_addr[1:0]. Storage is little-endian: lane 0 = bits [7:0].
- Align error if any of: size=11; half with addr[0]=1; word with addr[1:0]!=00. Range error if word index >= DEPTH_WORDS.
- When both errors apply, both flags are set. An errored request writes nothing, returns rd_data=0 and still produces rsp_valid.
- Store: on the accept edge, only the addressed lanes are written.
  - byte: lane = addr[1:0]
  - half: lanes {addr[1],0} and {addr[1],1}
  - word: all four lanes
  - Other lanes are unchanged.
- Load: the word is read, the addressed byte/half is selected and shifted to bit 0, then sign- or zero-extended per req_unsigned. Word loads ignore req_unsigned.
- Latency:
  - READ_LATENCY=1: the response is registered on the accept edge, and rsp_valid is high in the following cycle.
  - READ_LATENCY=2: an additional output register stage is added, so the response is visible 2 cycles after acceptance.
- Ordering: responses come out in acceptance order with no gaps or reordering.
- Read-after-write: the store commits on its accept edge. A load accepted in any later cycle sees the new data, including back-to-back store→load to the same address. No forwarding logic is required beyond this.
- Store responses assert rsp_valid with rd_data=0 and error flags as computed.
- rst asserted mid-operation: in-flight responses are dropped (no rsp_valid after reset). A store whose accept edge occurred before rst rose remains committed.
- Output registers hold their last value while rsp_valid=0. The checker must qualify rsp_* with rsp_valid.

Test Plan:
1. SW 0xDEADBEEF @0x10, then LW @0x10 → one rsp with rd_data=0x00000000 (store), then rd_data=0xDEADBEEF, errs 0; rsp_valid exactly READ_LATENCY cycles after each accept.
2. After test 1, SB 0x55 @0x12, then LW @0x10 → 0xDE55BEEF; LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x10 → 0xFFFFBEEF; LHU @0x12 → 0x0000DE55.
3. SH 0x1234 @0x21 → rsp_err_align=1, rd_data=0, memory @0x20 unchanged (LW returns prior value); LW @0x22 → rsp_err_align=1; size=11 @0x0 → rsp_err_align=1.
4. LW @ (DEPTH_WORDS*4) and SW @ (DEPTH_WORDS*4) → rsp_err_range=1, rd_data=0; word 0 not aliased/overwritten.
5. 200 back-to-back random requests at 1 req/cycle, both READ_LATENCY values → every accepted request produces exactly one in-order rsp matching a byte-lane reference model.
6. Issue LW, SW, LW on consecutive cycles, raise rst one cycle later → rsp_valid and all rsp_* go to 0 asynchronously, no stale responses after release; the committed SW is visible to a post-reset LW.
